// File: rtl/if_stage.sv
// Instruction-fetch stage: owns PC_F, the single-outstanding imem handshake and the IF/ID register.
// Optional `IF_MISALIGN_FAULT_EN`: misaligned redirect raises sticky FETCH_FAULT and parks fetch.
//   state   | meaning
//   IDLE    | post-reset (or fault-parked); no request
//   REQ     | IMEM_REQ high on PC_F, waiting for grant
//   WAIT    | granted, waiting for the response
//   DISCARD | redirected after grant; drop the stale response
//   HOLD    | response captured while decode is stalled
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        STALL_IF,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] PC_ID,
    output logic [31:0] INSTRUCTION_ID,
    output logic        VALID_ID
`ifdef IF_MISALIGN_FAULT_EN
    ,
    output logic        FETCH_FAULT
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD,
        S_HOLD
    } state_t;

    state_t      state;
    logic        req_q;
    logic [31:0] pc_f;
    logic [31:0] hold_buf;
    logic [31:0] target;
    logic        deliver;
    logic [31:0] deliver_insn;

`ifdef IF_MISALIGN_FAULT_EN
    logic fault_q;
    logic fault_hit;

    assign target    = BRANCH_TARGET;
    assign fault_hit = BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
    assign FETCH_FAULT = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (fault_hit) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign target = BRANCH_TARGET & 32'hFFFF_FFFC;
`endif

    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = pc_f;

    // A word reaches decode only on an edge with no flush and no stall.
    always_comb begin
        deliver      = 1'b0;
        deliver_insn = IMEM_RDATA;
        if (!BRANCH_TAKEN && !STALL_IF) begin
            if (state == S_WAIT && IMEM_RVALID) begin
                deliver = 1'b1;
            end else if (state == S_HOLD) begin
                deliver      = 1'b1;
                deliver_insn = hold_buf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            req_q    <= 1'b0;
            pc_f     <= RESET_PC;
            hold_buf <= 32'h0;
`ifdef IF_MISALIGN_FAULT_EN
        end else if (fault_q || fault_hit) begin
            state <= S_IDLE;
            req_q <= 1'b0;
            if (fault_hit && !fault_q) begin
                pc_f <= target;
            end
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                    req_q <= 1'b1;
                    if (BRANCH_TAKEN) begin
                        pc_f <= target;
                    end
                end
                S_REQ: begin
                    if (BRANCH_TAKEN) begin
                        pc_f <= target;
                        if (IMEM_GNT) begin
                            state <= S_DISCARD;
                            req_q <= 1'b0;
                        end
                    end else if (IMEM_GNT) begin
                        state <= S_WAIT;
                        req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (BRANCH_TAKEN) begin
                        pc_f <= target;
                        if (IMEM_RVALID) begin
                            state <= S_REQ;
                            req_q <= 1'b1;
                        end else begin
                            state <= S_DISCARD;
                        end
                    end else if (IMEM_RVALID) begin
                        if (STALL_IF) begin
                            hold_buf <= IMEM_RDATA;
                            state    <= S_HOLD;
                        end else begin
                            pc_f  <= pc_f + 32'd4;
                            state <= S_REQ;
                            req_q <= 1'b1;
                        end
                    end
                end
                S_DISCARD: begin
                    if (BRANCH_TAKEN) begin
                        pc_f <= target;
                    end
                    if (IMEM_RVALID) begin
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (BRANCH_TAKEN) begin
                        pc_f  <= target;
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end else if (!STALL_IF) begin
                        pc_f  <= pc_f + 32'd4;
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Flush beats stall; an idle edge inserts a bubble but keeps PC_ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC_ID          <= 32'h0;
            INSTRUCTION_ID <= NOP_INSN;
            VALID_ID       <= 1'b0;
        end else if (BRANCH_TAKEN) begin
            INSTRUCTION_ID <= NOP_INSN;
            VALID_ID       <= 1'b0;
        end else if (!STALL_IF) begin
            if (deliver) begin
                PC_ID          <= pc_f;
                INSTRUCTION_ID <= deliver_insn;
                VALID_ID       <= 1'b1;
            end else begin
                INSTRUCTION_ID <= NOP_INSN;
                VALID_ID       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed fetch scenarios against a latency-configurable memory model.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_if;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_id;
    logic [31:0] insn_id;
    logic        valid_id;
`ifdef IF_MISALIGN_FAULT_EN
    logic        fetch_fault;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_pop = 0;
    int   pop_cyc[64];
    int   rv_cyc = 0;
    int   lat = 1;
    int   gnt_delay = 0;
    bit   mem_en = 1'b0;
    logic stall_q = 1'b0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk),
        .rst_n(rst_n),
        .STALL_IF(stall_if),
        .BRANCH_TAKEN(branch_taken),
        .BRANCH_TARGET(branch_target),
        .IMEM_REQ(imem_req),
        .IMEM_ADDR(imem_addr),
        .IMEM_GNT(imem_gnt),
        .IMEM_RVALID(imem_rvalid),
        .IMEM_RDATA(imem_rdata),
        .PC_ID(pc_id),
        .INSTRUCTION_ID(insn_id),
        .VALID_ID(valid_id)
`ifdef IF_MISALIGN_FAULT_EN
        ,
        .FETCH_FAULT(fetch_fault)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (32'hC0DE_0000 ^ a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.insn = mem_word(a);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [31:0] a);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (imem_gnt && imem_addr == a) return;
        end
        checks++;
        failures++;
        $display("FAIL gnt_timeout: no grant for addr %h, expected one within 100 cycles", a);
    endtask

    task automatic wait_pops(input int target);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (n_pop >= target) return;
        end
        checks++;
        failures++;
        $display("FAIL pop_timeout: got %0d deliveries expected %0d", n_pop, target);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            stall_q = stall_if;
        end
    end

    // Monitor: a fresh IF/ID load is a valid instruction after an edge with no stall.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid_id && !stall_q) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got pc %h insn %h expected no delivery", pc_id, insn_id);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", pc_id, e.pc);
                    chk("sb_insn", insn_id, e.insn);
                end
                if (n_pop < 64) pop_cyc[n_pop] = cyc;
                n_pop++;
            end
        end
    end

    // Memory model: optional grant delay, response 'lat' cycles after grant, one outstanding.
    initial begin
        bit          pend;
        int          lc;
        int          gw;
        logic [31:0] pa;
        pend = 1'b0;
        lc = 0;
        gw = 0;
        pa = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            imem_gnt = 1'b0;
            imem_rvalid = 1'b0;
            if (pend) begin
                if (lc <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = mem_word(pa);
                    pend = 1'b0;
                    rv_cyc = cyc;
                end else begin
                    lc--;
                end
            end else if (imem_req && mem_en) begin
                if (gw < gnt_delay) begin
                    gw++;
                end else begin
                    imem_gnt = 1'b1;
                    pend = 1'b1;
                    pa = imem_addr;
                    lc = lat;
                    gw = 0;
                end
            end else begin
                gw = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int base;
        int rel;
        rst_n = 1'b0;
        stall_if = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        mem_en = 1'b1;
        lat = 1;
        gnt_delay = 0;
        repeat (3) tick();

        // Reset state and first fetch with 1-cycle memory
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc_id", pc_id, 32'h0);
        chk("rst_insn", insn_id, NOP);
        chk("rst_valid", {31'h0, valid_id}, 32'h0);
`ifdef IF_MISALIGN_FAULT_EN
        chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
`endif
        rst_n = 1'b1;
        chk("first_cycle_req", {31'h0, imem_req}, 32'h0);
        push_exp(32'h0);
        push_exp(32'h4);
        tick();
        chk("second_cycle_req", {31'h0, imem_req}, 32'h1);
        chk("second_cycle_addr", imem_addr, 32'h0);
        chk("addr0_granted", {31'h0, imem_gnt}, 32'h1);
        wait_pops(1);
        chk("latency", pop_cyc[0], rv_cyc + 1);
        chk("next_req", {31'h0, imem_req}, 32'h1);
        chk("next_addr", imem_addr, 32'h4);
        mem_en = 1'b0;
        wait_pops(2);

        // Redirect in the grant cycle for address 8
        lat = 2;
        mem_en = 1'b1;
        wait_gnt(32'h8);
        branch_taken = 1'b1;
        branch_target = 32'h100;
        mem_en = 1'b0;
        tick();
        branch_taken = 1'b0;
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", {31'h0, valid_id}, 32'h0);
        chk("redir_insn", insn_id, NOP);
        chk("redir_discard_req", {31'h0, imem_req}, 32'h0);
        tick();
        tick();
        chk("after_discard_req", {31'h0, imem_req}, 32'h1);
        chk("after_discard_addr", imem_addr, 32'h100);
        push_exp(32'h100);
        base = n_pop;
        mem_en = 1'b1;
        wait_gnt(32'h100);
        mem_en = 1'b0;
        wait_pops(base + 1);

        // 3-cycle latency, grant one cycle after request: 5-cycle cadence
        lat = 3;
        gnt_delay = 1;
        push_exp(32'h104);
        push_exp(32'h108);
        push_exp(32'h10C);
        base = n_pop;
        mem_en = 1'b1;
        wait_gnt(32'h10C);
        mem_en = 1'b0;
        wait_pops(base + 3);
        chk("cadence_1", pop_cyc[base + 1] - pop_cyc[base], 32'd5);
        chk("cadence_2", pop_cyc[base + 2] - pop_cyc[base + 1], 32'd5);
        gnt_delay = 0;

        // Stall for 4 cycles while waiting for a response
        push_exp(32'h110);
        base = n_pop;
        mem_en = 1'b1;
        wait_gnt(32'h110);
        mem_en = 1'b0;
        tick();
        stall_if = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_req", {31'h0, imem_req}, 32'h0);
            chk("stall_valid", {31'h0, valid_id}, 32'h0);
            chk("stall_pc_id", pc_id, 32'h10C);
        end
        stall_if = 1'b0;
        rel = cyc;
        wait_pops(base + 1);
        chk("release_latency", pop_cyc[base] - rel, 32'd1);
        chk("release_addr", imem_addr, 32'h114);
        chk("release_req", {31'h0, imem_req}, 32'h1);

        // Flush and stall together with a valid instruction in IF/ID
        lat = 1;
        push_exp(32'h114);
        base = n_pop;
        mem_en = 1'b1;
        wait_gnt(32'h114);
        mem_en = 1'b0;
        wait_pops(base + 1);
        stall_if = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h200;
        tick();
        chk("flush_valid", {31'h0, valid_id}, 32'h0);
        chk("flush_insn", insn_id, NOP);
        chk("flush_addr", imem_addr, 32'h200);
        chk("flush_pc_id", pc_id, 32'h114);
        stall_if = 1'b0;
        branch_taken = 1'b0;

        // Reset mid-transaction; the stale response lands while back in REQ
        lat = 3;
        mem_en = 1'b1;
        wait_gnt(32'h200);
        mem_en = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'h0, imem_req}, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_pc_id", pc_id, 32'h0);
        chk("midrst_insn", insn_id, NOP);
        chk("midrst_valid", {31'h0, valid_id}, 32'h0);
        tick();
        rst_n = 1'b1;
        push_exp(32'h0);
        base = n_pop;
        mem_en = 1'b1;
        wait_gnt(32'h0);
        mem_en = 1'b0;
        wait_pops(base + 1);

        // PC wrap from the top of the address space
        tick();
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
        lat = 1;
        push_exp(32'hFFFF_FFFC);
        base = n_pop;
        mem_en = 1'b1;
        wait_gnt(32'hFFFF_FFFC);
        mem_en = 1'b0;
        wait_pops(base + 1);
        chk("wrap_next", imem_addr, 32'h0);

        // Misaligned redirect
        tick();
        branch_taken = 1'b1;
        branch_target = 32'h102;
        tick();
        branch_taken = 1'b0;
`ifdef IF_MISALIGN_FAULT_EN
        chk("fault_set", {31'h0, fetch_fault}, 32'h1);
        chk("fault_req", {31'h0, imem_req}, 32'h0);
        mem_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("parked_req", {31'h0, imem_req}, 32'h0);
            chk("parked_valid", {31'h0, valid_id}, 32'h0);
        end
        mem_en = 1'b0;
`else
        chk("misalign_addr", imem_addr, 32'h100);
        chk("misalign_req", {31'h0, imem_req}, 32'h1);
        push_exp(32'h100);
        base = n_pop;
        mem_en = 1'b1;
        wait_gnt(32'h100);
        mem_en = 1'b0;
        wait_pops(base + 1);
`endif

        repeat (3) tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
